usb_rx_core: RTL and testbench

//  Parametrised full-speed USB receiver: 2-FF sync, edge detect, bit timer, NRZI decode,

---
 rtl/usb_rx_core.sv | 153 +++++++++++++++
 tb/tb_usb_rx_core.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_core.sv
// usb_rx_core: full-speed USB receiver from raw D+/D- pads to a byte FIFO.
//   Chain: 2-FF synchroniser, edge detect, bit timer, NRZI decode, SYNC check,
//   receive FSM and a show-ahead byte FIFO with overflow and fill-level reporting.
// Ports:
//   clk      in   system clock, rising edge
//   n_rst    in   asynchronous active-low reset
//   d_plus   in   raw D+ (asynchronous)
//   d_minus  in   raw D- (asynchronous)
//   r_enable in   pop one byte from the FIFO
//   r_data   out  FIFO head byte, valid when !empty
//   empty    out  FIFO empty
//   full     out  FIFO full
//   count    out  FIFO fill level
//   rcving   out  packet in progress
//   r_error  out  sticky packet error, cleared when the next packet starts
// Option: define USB_RX_BITSTUFF_EN to discard the bit following six consecutive ones
//   and flag an error if that bit is a one.
module usb_rx_core #(
    parameter int         CLKS_PER_BIT = 8,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'h80
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        d_plus,
    input  logic                        d_minus,
    input  logic                        r_enable,
    output logic [7:0]                  r_data,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        rcving,
    output logic                        r_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_MID  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   C_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_RECV = 3'd2;
    localparam logic [2:0] S_EOPW = 3'd3;
    localparam logic [2:0] S_ERRW = 3'd4;

    logic          r_dp_meta, r_dp_s, r_dm_meta, r_dm_s, r_dp_prev, r_prev_lvl, r_seen_eop;
    logic [TW-1:0] r_tmr;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt, r_state, w_next;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_eop, w_edge, w_j, w_start, w_shift_en, w_bit, w_sample, w_stuff, w_keep;
    logic          w_byte_done, w_stuff_err, w_push_req, w_pop, w_push, w_ovf;
    logic [7:0]    w_byte;

    assign w_eop       = !r_dp_s && !r_dm_s;
    assign w_edge      = r_dp_s ^ r_dp_prev;
    assign w_j         = r_dp_s && !w_eop;
    assign rcving      = r_state != S_IDLE;
    assign w_start     = (r_state == S_IDLE) && w_edge && !w_eop;
    assign w_shift_en  = rcving && (r_tmr == T_MID);
    assign w_bit       = r_dp_s == r_prev_lvl;
    // Only SYNC/RECV consume bits; an SE0 sample is an EOP marker, never data.
    assign w_sample    = w_shift_en && !w_eop && (r_state == S_SYNC || r_state == S_RECV);
    assign w_keep      = w_sample && !w_stuff;
    assign w_byte      = {w_bit, r_shift[7:1]};
    assign w_byte_done = w_keep && (r_bit_cnt == 3'd7);
    assign w_stuff_err = w_sample && w_stuff && w_bit;
    assign w_push_req  = (r_state == S_RECV) && w_byte_done;
    assign w_pop       = r_enable && (r_count != '0);
    assign w_push      = w_push_req && ((r_count != C_FULL) || w_pop);
    assign w_ovf       = w_push_req && (r_count == C_FULL) && !w_pop;
    assign r_data      = r_mem[r_rd_ptr];
    assign empty       = r_count == '0;
    assign full        = r_count == C_FULL;
    assign count       = r_count;

`ifdef USB_RX_BITSTUFF_EN
    logic [2:0] r_ones;
    assign w_stuff = r_ones == 3'd6;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_ones <= '0;
        else if (w_start) r_ones <= '0;
        else if (w_sample) r_ones <= (w_stuff || !w_bit) ? 3'd0 : r_ones + 3'd1;
    end
`else
    assign w_stuff = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = w_start ? S_SYNC : S_IDLE;
            S_SYNC: if (w_eop || w_stuff_err) w_next = S_ERRW;
                    else if (w_byte_done) w_next = (w_byte == SYNC_BYTE) ? S_RECV : S_ERRW;
            S_RECV: if (w_shift_en && w_eop) w_next = (r_bit_cnt == 3'd0) ? S_EOPW : S_ERRW;
                    else if (w_stuff_err) w_next = S_ERRW;
            S_EOPW: if (w_j) w_next = S_IDLE;
            S_ERRW: if (r_seen_eop && w_j) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_dp_meta  <= 1'b1;
            r_dp_s     <= 1'b1;
            r_dm_meta  <= 1'b0;
            r_dm_s     <= 1'b0;
            r_dp_prev  <= 1'b1;
            r_prev_lvl <= 1'b1;
            r_tmr      <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_state    <= S_IDLE;
            r_seen_eop <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_dp_meta  <= d_plus;
            r_dp_s     <= r_dp_meta;
            r_dm_meta  <= d_minus;
            r_dm_s     <= r_dm_meta;
            r_dp_prev  <= r_dp_s;
            r_tmr      <= (!rcving || w_edge || r_tmr == T_END) ? '0 : r_tmr + TW'(1);
            if (r_state == S_IDLE) r_prev_lvl <= 1'b1;
            else if (w_shift_en) r_prev_lvl <= w_eop ? 1'b1 : r_dp_s;
            if (w_keep) r_shift <= w_byte;
            if (w_start) r_bit_cnt <= '0;
            else if (w_keep) r_bit_cnt <= r_bit_cnt + 3'd1;
            r_state    <= w_next;
            // The leaving J only counts once the error path has actually seen SE0.
            r_seen_eop <= (r_state == S_ERRW) && (r_seen_eop || w_eop);
            r_error    <= w_start ? 1'b0 : (r_error || w_ovf || w_next == S_ERRW);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_byte;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        end
    end
endmodule

// File: tb/tb_usb_rx_core.sv
// tb_usb_rx_core: self-checking bench for usb_rx_core (8 clk/bit, 4-deep FIFO).
//   Packets are NRZI-encoded on D+/D- by the bench; expected bytes, levels and
//   error flags are hand-computed. Bit-stuff cases run when USB_RX_BITSTUFF_EN is defined.
module tb_usb_rx_core;
    logic       clk, n_rst, d_plus, d_minus, r_enable;
    logic [7:0] r_data;
    logic       empty, full, rcving, r_error;
    logic [2:0] count;
    logic       lvl;
    int         n_chk, n_fail;

    typedef struct {
        logic [7:0]  sync;
        int          nb;
        logic [47:0] d;
        int          tail_bits;
        logic [7:0]  tail;
        int          cnt;
        logic        full;
        logic        err;
        int          np;
        logic [31:0] pops;
    } vec_t;
    vec_t vecs [6];

    usb_rx_core #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4), .SYNC_BYTE(8'h80)) dut (
        .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .d_minus(d_minus), .r_enable(r_enable),
        .r_data(r_data), .empty(empty), .full(full), .count(count), .rcving(rcving),
        .r_error(r_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One NRZI bit: a 0 toggles the line. Optional single-cycle pop lands on the
    // cycle the receiver samples this bit (mid-bit, after the 2-flop synchroniser).
    task automatic send_bit(input logic b, input logic pop);
        if (!b) lvl = !lvl;
        d_plus  = lvl;
        d_minus = !lvl;
        repeat (6) @(negedge clk);
        r_enable = pop;
        @(negedge clk);
        r_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input int n, input logic pop_last);
        for (int i = 0; i < n; i++) send_bit(v[i], pop_last && i == 7);
    endtask

    task automatic send_eop();
        d_plus  = 1'b0;
        d_minus = 1'b0;
        repeat (16) @(negedge clk);
        lvl     = 1'b1;
        d_plus  = 1'b1;
        d_minus = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic pop_chk(input string nm, input logic [7:0] exp);
        chk(nm, r_data, exp);
        r_enable = 1'b1;
        @(negedge clk);
        r_enable = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        n_rst = 1'b0;
        d_plus = 1'b1;
        d_minus = 1'b0;
        r_enable = 1'b0;
        lvl = 1'b1;
        vecs[0] = '{8'h80, 2, 48'h3CA5, 0, 8'h00, 2, 1'b0, 1'b0, 2, 32'h3CA5};
        vecs[1] = '{8'h81, 1, 48'hA5, 0, 8'h00, 0, 1'b0, 1'b1, 0, 32'h0};
        vecs[2] = '{8'h80, 1, 48'h5A, 0, 8'h00, 1, 1'b0, 1'b0, 1, 32'h5A};
        vecs[3] = '{8'h80, 1, 48'hC3, 3, 8'h05, 1, 1'b0, 1'b1, 1, 32'hC3};
        vecs[4] = '{8'h80, 6, 48'h665544332211, 0, 8'h00, 4, 1'b1, 1'b1, 4, 32'h44332211};
        vecs[5] = '{8'h80, 3, 48'h813E00, 0, 8'h00, 3, 1'b0, 1'b0, 3, 32'h813E00};

        repeat (3) @(negedge clk);
        chk("reset r_data", r_data, 8'h00);
        chk("reset empty", empty, 1'b1);
        chk("reset full", full, 1'b0);
        chk("reset count", count, 3'd0);
        chk("reset rcving", rcving, 1'b0);
        chk("reset r_error", r_error, 1'b0);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);

        send_byte(8'h80, 8, 1'b0);
        send_byte(8'hA5, 8, 1'b0);
        chk("p1 empty after byte1", empty, 1'b0);
        chk("p1 count after byte1", count, 3'd1);
        chk("p1 rcving mid", rcving, 1'b1);
        send_byte(8'h3C, 8, 1'b0);
        send_eop();
        chk("p1 count", count, 3'd2);
        chk("p1 r_error", r_error, 1'b0);
        chk("p1 rcving after J", rcving, 1'b0);
        pop_chk("p1 pop1", 8'hA5);
        pop_chk("p1 pop2", 8'h3C);
        chk("p1 empty after pops", empty, 1'b1);

        send_byte(8'h80, 8, 1'b0);
        send_byte(8'hA5, 8, 1'b0);
        send_byte(8'h0F, 3, 1'b0);
        lvl = 1'b1;
        d_plus = 1'b1;
        d_minus = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("rst mid count", count, 3'd0);
        chk("rst mid empty", empty, 1'b1);
        chk("rst mid rcving", rcving, 1'b0);
        chk("rst mid r_data", r_data, 8'h00);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst idle rcving", rcving, 1'b0);

        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].sync, 8, 1'b0);
            for (int j = 0; j < vecs[i].nb; j++) send_byte(vecs[i].d[8*j +: 8], 8, 1'b0);
            if (vecs[i].tail_bits > 0) send_byte(vecs[i].tail, vecs[i].tail_bits, 1'b0);
            chk($sformatf("v%0d rcving mid", i), rcving, 1'b1);
            send_eop();
            chk($sformatf("v%0d count", i), count, vecs[i].cnt);
            chk($sformatf("v%0d full", i), full, vecs[i].full);
            chk($sformatf("v%0d empty", i), empty, vecs[i].cnt == 0);
            chk($sformatf("v%0d r_error", i), r_error, vecs[i].err);
            chk($sformatf("v%0d rcving", i), rcving, 1'b0);
            for (int k = 0; k < vecs[i].np; k++)
                pop_chk($sformatf("v%0d pop%0d", i, k), vecs[i].pops[8*k +: 8]);
            chk($sformatf("v%0d drained", i), count, 3'd0);
        end

        send_byte(8'h80, 8, 1'b0);
        send_byte(8'h12, 8, 1'b0);
        send_byte(8'h34, 8, 1'b0);
        send_byte(8'h56, 8, 1'b0);
        send_byte(8'h78, 8, 1'b0);
        chk("pp full before", full, 1'b1);
        send_byte(8'h9A, 8, 1'b1);
        chk("pp count", count, 3'd4);
        chk("pp full", full, 1'b1);
        chk("pp r_error", r_error, 1'b0);
        chk("pp head", r_data, 8'h34);
        send_eop();
        pop_chk("pp pop1", 8'h34);
        pop_chk("pp pop2", 8'h56);
        pop_chk("pp pop3", 8'h78);
        pop_chk("pp pop4", 8'h9A);
        chk("pp empty", empty, 1'b1);
        r_enable = 1'b1;
        @(negedge clk);
        r_enable = 1'b0;
        @(negedge clk);
        chk("empty pop count", count, 3'd0);
        chk("empty pop empty", empty, 1'b1);
        chk("empty pop full", full, 1'b0);
        send_byte(8'h80, 8, 1'b0);
        send_byte(8'hBD, 8, 1'b0);
        send_eop();
        chk("after empty pop count", count, 3'd1);
        pop_chk("after empty pop data", 8'hBD);

`ifdef USB_RX_BITSTUFF_EN
        send_byte(8'h80, 8, 1'b0);
        send_byte(8'h1F, 5, 1'b0);
        send_bit(1'b0, 1'b0);
        send_byte(8'h07, 3, 1'b0);
        send_eop();
        chk("stuff count", count, 3'd1);
        chk("stuff r_error", r_error, 1'b0);
        pop_chk("stuff data", 8'hFF);
        send_byte(8'h80, 8, 1'b0);
        send_byte(8'h3F, 6, 1'b0);
        send_eop();
        chk("stuff viol r_error", r_error, 1'b1);
        chk("stuff viol count", count, 3'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
